// File: rtl/seq1001_pkg.sv
// Shared types and constants for the 1001-framed serial transmitter.
package seq1001_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        SYNC   = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        GAP    = 3'b100
    } state_t;

    localparam logic [3:0]  SYNC_PATTERN = 4'b1001;
    localparam int unsigned SYNC_LEN     = 4;

    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned gap_bits,
                                              input bit          parity_en);
        return SYNC_LEN + data_w + gap_bits + (parity_en ? 1 : 0);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Parallel-load, MSB-first shift register; o_sout is the current MSB.
module seq_tx_shifter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_sout
);

    logic [W-1:0] r_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= r_sh << 1;
        end
    end

    assign o_sout = r_sh[W-1];

endmodule

// File: rtl/sequence_1001_tx.sv
// Serial frame transmitter: 1001 sync, MSB-first payload, optional even parity
// (SEQ_TX_PARITY_EN), then GAP_BITS zeros; done pulses on return to IDLE.
module sequence_1001_tx
    import seq1001_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              x,
    output logic              busy,
    output logic              done,
    output logic [2:0]        curstate
);

    localparam int unsigned CNT_W = $clog2(max3(DATA_W, GAP_BITS, SYNC_LEN) + 1);

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               r_x;
    logic               r_busy;
    logic               r_done;
    logic               w_x_nx;
    logic               w_busy_nx;
    logic               w_done_nx;
    logic               w_load;
    logic               w_shift;
    logic               w_sout;
    logic [1:0]         w_sync_idx;
`ifdef SEQ_TX_PARITY_EN
    logic               r_parity;
`endif

    seq_tx_shifter #(.W(DATA_W)) u_shifter (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (data),
        .o_sout  (w_sout)
    );

    // r_cnt holds the bits still to follow the one currently on x in this state
    assign w_sync_idx = 2'(r_cnt - CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_x     <= w_x_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^data;
        end
    end
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_x_nx     = 1'b0;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy_nx = 1'b0;
                if (start) begin
                    w_state_nx = SYNC;
                    w_cnt_nx   = CNT_W'(SYNC_LEN - 1);
                    w_x_nx     = SYNC_PATTERN[3];
                    w_busy_nx  = 1'b1;
                    w_load     = 1'b1;
                end
            end
            SYNC: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    w_x_nx   = SYNC_PATTERN[w_sync_idx];
                end else begin
                    w_state_nx = DATA;
                    w_cnt_nx   = CNT_W'(DATA_W - 1);
                    w_x_nx     = w_sout;
                    w_shift    = 1'b1;
                end
            end
            DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    w_x_nx   = w_sout;
                    w_shift  = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    w_state_nx = PARITY;
                    w_cnt_nx   = '0;
                    w_x_nx     = r_parity;
`else
                    w_state_nx = GAP;
                    w_cnt_nx   = CNT_W'(GAP_BITS - 1);
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: begin
                w_state_nx = GAP;
                w_cnt_nx   = CNT_W'(GAP_BITS - 1);
            end
`endif
            GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign x        = r_x;
    assign busy     = r_busy;
    assign done     = r_done;
    assign curstate = r_state;

endmodule

// File: tb/tb_sequence_1001_tx.sv
// Directed bench for sequence_1001_tx (DATA_W=8, GAP_BITS=2), with an inline
// 1001 detector tap; adapts frame length when SEQ_TX_PARITY_EN is defined.
module tb_sequence_1001_tx;

`ifdef SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = 14 + PAR;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       x;
    logic       busy;
    logic       done;
    logic [2:0] curstate;

    int n_checks;
    int n_errors;

    sequence_1001_tx #(.DATA_W(8), .GAP_BITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data     (data),
        .x        (x),
        .busy     (busy),
        .done     (done),
        .curstate (curstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One frame. eb holds the hand-expected stream: 1001, payload, parity bit, 00.
    task automatic run_frame(input logic [7:0] d, input logic p, input int det_exp,
                             input bit pre, input bit repulse,
                             input bit chain, input logic [7:0] chain_d);
        logic [14:0] eb;
        logic [3:0]  det_sh;
        int          det_n;
        int          st_exp;
        eb     = {4'b1001, d, p, 2'b00};
        det_sh = 4'b0000;
        det_n  = 0;
        if (!pre) begin
            @(negedge clk);
            data  = d;
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = ~d;
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            if (repulse && i == 5) start = 1'b1;
            if (repulse && i == 6) start = 1'b0;
            if (i < 4)                  st_exp = 1;
            else if (i < 12)            st_exp = 2;
            else if (PAR == 1 && i == 12) st_exp = 3;
            else                        st_exp = 4;
            chk($sformatf("x[%0d] d=%02h", i, d), int'(x), (i < 12 + PAR) ? int'(eb[14-i]) : 0);
            chk($sformatf("busy[%0d]", i), int'(busy), 1);
            chk($sformatf("done[%0d]", i), int'(done), 0);
            chk($sformatf("state[%0d]", i), int'(curstate), st_exp);
            det_sh = {det_sh[2:0], x};
            if (det_sh == 4'b1001) det_n++;
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_state", int'(curstate), 0);
        chk("done_x", int'(x), 0);
        chk($sformatf("detector d=%02h", d), det_n, det_exp);
        if (chain) begin
            data  = chain_d;
            start = 1'b1;
        end else begin
            @(negedge clk);
            chk("done_once", int'(done), 0);
            chk("idle_state", int'(curstate), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        #2;
        chk("rst_x", int'(x), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_state", int'(curstate), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_x", int'(x), 0);

        // A5 with a stray start mid-frame, start held through done -> FF back-to-back
        run_frame(8'hA5, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'hFF);
        run_frame(8'hFF, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Reset in DATA while x=1 (payload bit 5 of A5)
        @(negedge clk);
        data  = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_x", int'(x), 1);
        chk("pre_rst_state", int'(curstate), 2);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_x", int'(x), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_state", int'(curstate), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("no_done[%0d]", i), int'(done), 0);
        end

        run_frame(8'h3C, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00);
        run_frame(8'h07, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
